// File: rtl/page_bitmap_alloc_pkg.sv
// Shared definitions for the page-bitmap allocator: FSM encoding and width helpers.
package page_bitmap_alloc_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_A_RD,
    ST_A_CHK,
    ST_F_RD,
    ST_F_CHK
  } state_e;

  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  function automatic int idx_width(input int addr_width, input int data_width);
    return addr_width + clog2(data_width);
  endfunction

endpackage

// File: rtl/page_bitmap_alloc_ffz_enc.sv
// Find-first-zero over one bitmap word: index of the lowest clear bit, plus a full-word flag.
module ffz_enc
  import page_bitmap_alloc_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  localparam int BIT_W = clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] vec_i,
  output logic [BIT_W-1:0]      idx_o,
  output logic                  all_ones_o
);

  // Scan from the top so the lowest clear bit is the last one assigned.
  always_comb begin
    idx_o = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (!vec_i[i]) begin
        idx_o = BIT_W'(i);
      end
    end
  end

  assign all_ones_o = &vec_i;

endmodule

// File: rtl/page_bitmap_alloc.sv
// Page allocator: one bit per page in a dual-port bitmap RAM, read on port A and written back on
// port B. Alloc/free are single-outstanding read-modify-write ops; responses come 3 cycles after accept.
module page_bitmap_alloc
  import page_bitmap_alloc_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6,
  localparam int BIT_W = clog2(DATA_WIDTH),
  localparam int IDX_W = idx_width(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  alloc_req_valid,
  output logic                  alloc_req_ready,
  output logic                  alloc_resp_valid,
  output logic [IDX_W-1:0]      alloc_resp_idx,
  output logic                  alloc_resp_fail,
  input  logic                  free_req_valid,
  output logic                  free_req_ready,
  input  logic [IDX_W-1:0]      free_req_idx,
  output logic                  free_resp_valid,
  output logic                  free_resp_err,
  output logic                  ram_wen_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_data_a,
  input  logic [DATA_WIDTH-1:0] ram_q_a,
  output logic                  ram_wen_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_data_b
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [ADDR_WIDTH-1:0] hint_q, hint_d;
  logic [ADDR_WIDTH-1:0] probe_q, probe_d;
  logic [IDX_W-1:0]      free_idx_q, free_idx_d;
  logic                  init_done_q, init_done_d;
  logic                  a_vld_q, a_vld_d;
  logic [IDX_W-1:0]      a_idx_q, a_idx_d;
  logic                  a_fail_q, a_fail_d;
  logic                  f_vld_q, f_vld_d;
  logic                  f_err_q, f_err_d;

  logic [BIT_W-1:0]      ffz_idx;
  logic                  ffz_full;
  logic [DATA_WIDTH-1:0] alloc_mask;
  logic [DATA_WIDTH-1:0] free_mask;
  logic [ADDR_WIDTH-1:0] free_word;

  ffz_enc #(.DATA_WIDTH(DATA_WIDTH)) u_ffz (
    .vec_i      (ram_q_a),
    .idx_o      (ffz_idx),
    .all_ones_o (ffz_full)
  );

  assign alloc_mask = ONE << ffz_idx;
  assign free_mask  = ONE << free_idx_q[BIT_W-1:0];
  assign free_word  = free_idx_q[IDX_W-1:BIT_W];

  always_comb begin
    state_d         = state_q;
    init_cnt_d      = init_cnt_q;
    hint_d          = hint_q;
    probe_d         = probe_q;
    free_idx_d      = free_idx_q;
    init_done_d     = init_done_q;
    a_vld_d         = 1'b0;
    a_idx_d         = a_idx_q;
    a_fail_d        = a_fail_q;
    f_vld_d         = 1'b0;
    f_err_d         = f_err_q;
    alloc_req_ready = 1'b0;
    free_req_ready  = 1'b0;
    ram_wen_a       = 1'b0;
    ram_addr_a      = '0;
    ram_data_a      = '0;
    ram_wen_b       = 1'b0;
    ram_addr_b      = '0;
    ram_data_b      = '0;

    case (state_q)
      ST_INIT: begin
        ram_wen_a  = 1'b1;
        ram_addr_a = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        free_req_ready  = 1'b1;
        alloc_req_ready = !free_req_valid;
        if (free_req_valid) begin
          free_idx_d = free_req_idx;
          state_d    = ST_F_RD;
        end else if (alloc_req_valid) begin
          probe_d = '0;
          state_d = ST_A_RD;
        end
      end
      ST_A_RD: begin
        ram_addr_a = hint_q;
        state_d    = ST_A_CHK;
      end
      ST_A_CHK: begin
        if (!ffz_full) begin
          ram_wen_b  = 1'b1;
          ram_addr_b = hint_q;
          ram_data_b = ram_q_a | alloc_mask;
          a_vld_d    = 1'b1;
          a_idx_d    = {hint_q, ffz_idx};
          a_fail_d   = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          // Wrapping increment: after a full sweep the hint is back where it started.
          hint_d = hint_q + 1'b1;
          if (probe_q == '1) begin
            a_vld_d  = 1'b1;
            a_idx_d  = '0;
            a_fail_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            probe_d = probe_q + 1'b1;
            state_d = ST_A_RD;
          end
        end
      end
      ST_F_RD: begin
        ram_addr_a = free_word;
        state_d    = ST_F_CHK;
      end
      ST_F_CHK: begin
        f_vld_d = 1'b1;
        state_d = ST_IDLE;
        if (|(ram_q_a & free_mask)) begin
          ram_wen_b  = 1'b1;
          ram_addr_b = free_word;
          ram_data_b = ram_q_a & ~free_mask;
          f_err_d    = 1'b0;
        end else begin
          f_err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      hint_q      <= '0;
      probe_q     <= '0;
      free_idx_q  <= '0;
      init_done_q <= 1'b0;
      a_vld_q     <= 1'b0;
      a_idx_q     <= '0;
      a_fail_q    <= 1'b0;
      f_vld_q     <= 1'b0;
      f_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      hint_q      <= hint_d;
      probe_q     <= probe_d;
      free_idx_q  <= free_idx_d;
      init_done_q <= init_done_d;
      a_vld_q     <= a_vld_d;
      a_idx_q     <= a_idx_d;
      a_fail_q    <= a_fail_d;
      f_vld_q     <= f_vld_d;
      f_err_q     <= f_err_d;
    end
  end

  assign init_done        = init_done_q;
  assign alloc_resp_valid = a_vld_q;
  assign alloc_resp_idx   = a_idx_q;
  assign alloc_resp_fail  = a_fail_q;
  assign free_resp_valid  = f_vld_q;
  assign free_resp_err    = f_err_q;

endmodule

// File: tb/tb_page_bitmap_alloc.sv
// Directed bench: default 64x64 allocator plus a tiny 4x8 instance for the exhaustion case.
module tb_page_bitmap_alloc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance 0: DATA_WIDTH=64, ADDR_WIDTH=6
  logic        rst0, init0, fill0;
  logic        a_vld0, a_rdy0, ar_vld0, ar_fail0;
  logic [11:0] ar_idx0;
  logic        f_vld0, f_rdy0, fr_vld0, fr_err0;
  logic [11:0] f_idx0;
  logic        wa0, wb0;
  logic [5:0]  aa0, ab0;
  logic [63:0] da0, db0, qa0;
  logic [63:0] mem0 [64];
  int          wb_cnt0 = 0;

  // Instance 1: DATA_WIDTH=8, ADDR_WIDTH=2
  logic        rst1, init1, fill1;
  logic        a_vld1, a_rdy1, ar_vld1, ar_fail1;
  logic [4:0]  ar_idx1;
  logic        f_vld1, f_rdy1, fr_vld1, fr_err1;
  logic [4:0]  f_idx1;
  logic        wa1, wb1;
  logic [1:0]  aa1, ab1;
  logic [7:0]  da1, db1, qa1;
  logic [7:0]  mem1 [4];

  page_bitmap_alloc dut0 (
    .clk(clk), .rst(rst0), .init_done(init0),
    .alloc_req_valid(a_vld0), .alloc_req_ready(a_rdy0),
    .alloc_resp_valid(ar_vld0), .alloc_resp_idx(ar_idx0), .alloc_resp_fail(ar_fail0),
    .free_req_valid(f_vld0), .free_req_ready(f_rdy0), .free_req_idx(f_idx0),
    .free_resp_valid(fr_vld0), .free_resp_err(fr_err0),
    .ram_wen_a(wa0), .ram_addr_a(aa0), .ram_data_a(da0), .ram_q_a(qa0),
    .ram_wen_b(wb0), .ram_addr_b(ab0), .ram_data_b(db0)
  );

  page_bitmap_alloc #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst1), .init_done(init1),
    .alloc_req_valid(a_vld1), .alloc_req_ready(a_rdy1),
    .alloc_resp_valid(ar_vld1), .alloc_resp_idx(ar_idx1), .alloc_resp_fail(ar_fail1),
    .free_req_valid(f_vld1), .free_req_ready(f_rdy1), .free_req_idx(f_idx1),
    .free_resp_valid(fr_vld1), .free_resp_err(fr_err1),
    .ram_wen_a(wa1), .ram_addr_a(aa1), .ram_data_a(da1), .ram_q_a(qa1),
    .ram_wen_b(wb1), .ram_addr_b(ab1), .ram_data_b(db1)
  );

  // Dual-port RAM models; 'fill' loads junk so the clear sweep is observable.
  always @(posedge clk) begin
    if (fill0) begin
      for (int i = 0; i < 64; i++) mem0[i] <= 64'hA5A5_5A5A_DEAD_BEEF;
    end else begin
      if (wa0) mem0[aa0] <= da0;
      if (wb0) mem0[ab0] <= db0;
    end
    qa0 <= mem0[aa0];
    if (wb0) wb_cnt0 <= wb_cnt0 + 1;
  end

  always @(posedge clk) begin
    if (fill1) begin
      for (int i = 0; i < 4; i++) mem1[i] <= 8'h5A;
    end else begin
      if (wa1) mem1[aa1] <= da1;
      if (wb1) mem1[ab1] <= db1;
    end
    qa1 <= mem1[aa1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic alloc0(output logic [11:0] idx, output logic fail, output int lat);
    int n = 0;
    a_vld0 = 1'b1;
    while (!a_rdy0 && n < 200) begin tick(); n++; end
    tick();
    a_vld0 = 1'b0;
    lat = 1;
    while (!ar_vld0 && lat < 200) begin tick(); lat++; end
    idx = ar_idx0;
    fail = ar_fail0;
  endtask

  task automatic free0(input logic [11:0] idx, output logic err, output int lat);
    int n = 0;
    f_vld0 = 1'b1;
    f_idx0 = idx;
    while (!f_rdy0 && n < 200) begin tick(); n++; end
    tick();
    f_vld0 = 1'b0;
    lat = 1;
    while (!fr_vld0 && lat < 200) begin tick(); lat++; end
    err = fr_err0;
  endtask

  task automatic alloc1(output logic [4:0] idx, output logic fail, output int lat);
    int n = 0;
    a_vld1 = 1'b1;
    while (!a_rdy1 && n < 200) begin tick(); n++; end
    tick();
    a_vld1 = 1'b0;
    lat = 1;
    while (!ar_vld1 && lat < 200) begin tick(); lat++; end
    idx = ar_idx1;
    fail = ar_fail1;
  endtask

  task automatic free1(input logic [4:0] idx, output logic err, output int lat);
    int n = 0;
    f_vld1 = 1'b1;
    f_idx1 = idx;
    while (!f_rdy1 && n < 200) begin tick(); n++; end
    tick();
    f_vld1 = 1'b0;
    lat = 1;
    while (!fr_vld1 && lat < 200) begin tick(); lat++; end
    err = fr_err1;
  endtask

  initial begin
    logic [11:0] idx0;
    logic [4:0]  idx1;
    logic        fl, er, seen;
    logic [63:0] acc;
    int          lat, n, wsave;

    a_vld0 = 0; f_vld0 = 0; f_idx0 = '0;
    a_vld1 = 0; f_vld1 = 0; f_idx1 = '0;
    fill0 = 1; fill1 = 1; rst0 = 1; rst1 = 1;
    tick();
    fill0 = 0; fill1 = 0;
    check("rst_init_done", 64'(init0), 0);
    check("rst_alloc_resp", 64'(ar_vld0), 0);
    check("rst_free_resp", 64'(fr_vld0), 0);
    rst0 = 0; rst1 = 0;

    n = 0; seen = 0;
    while (!init0 && n < 200) begin
      if (a_rdy0 || f_rdy0) seen = 1;
      tick(); n++;
    end
    check("init_cycles", 64'(n), 64);
    check("ready_in_init", 64'(seen), 0);
    acc = '0;
    for (int i = 0; i < 64; i++) acc |= mem0[i];
    check("init_clear0", acc, 0);
    acc = '0;
    for (int i = 0; i < 4; i++) acc |= 64'(mem1[i]);
    check("init_clear1", acc, 0);

    alloc0(idx0, fl, lat);
    check("a0_idx", 64'(idx0), 0);
    check("a0_fail", 64'(fl), 0);
    check("a0_lat", 64'(lat), 3);
    alloc0(idx0, fl, lat);
    check("a1_idx", 64'(idx0), 1);
    check("word0_after_2", mem0[0], 64'h3);

    free0(12'd1, er, lat);
    check("free1_err", 64'(er), 0);
    check("free1_lat", 64'(lat), 3);
    check("word0_after_free", mem0[0], 64'h1);
    alloc0(idx0, fl, lat);
    check("realloc_idx", 64'(idx0), 1);

    wsave = wb_cnt0;
    free0(12'd5, er, lat);
    check("dfree_err", 64'(er), 1);
    check("dfree_no_write", 64'(wb_cnt0), 64'(wsave));
    check("dfree_word0", mem0[0], 64'h3);

    // Simultaneous requests: free wins, alloc follows once idle again.
    f_idx0 = 12'd0; f_vld0 = 1; a_vld0 = 1;
    #1;
    check("both_free_rdy", 64'(f_rdy0), 1);
    check("both_alloc_rdy", 64'(a_rdy0), 0);
    tick();
    f_vld0 = 0;
    n = 1;
    while (!fr_vld0 && n < 200) begin tick(); n++; end
    check("both_free_lat", 64'(n), 3);
    check("both_free_err", 64'(fr_err0), 0);
    check("both_alloc_rdy2", 64'(a_rdy0), 1);
    tick();
    a_vld0 = 0;
    lat = 1;
    while (!ar_vld0 && lat < 200) begin tick(); lat++; end
    check("both_alloc_idx", 64'(ar_idx0), 0);
    check("both_alloc_lat", 64'(lat), 3);

    // Reset while an alloc sits in A_CHK.
    a_vld0 = 1;
    tick();
    a_vld0 = 0;
    tick();
    rst0 = 1;
    tick();
    rst0 = 0;
    check("midrst_resp", 64'(ar_vld0), 0);
    check("midrst_init_done", 64'(init0), 0);
    n = 0; seen = 0;
    while (!init0 && n < 200) begin
      if (ar_vld0) seen = 1;
      tick(); n++;
    end
    check("midrst_init_cycles", 64'(n), 64);
    check("midrst_no_resp", 64'(seen), 0);
    check("midrst_word0", mem0[0], 0);
    alloc0(idx0, fl, lat);
    check("midrst_alloc_idx", 64'(idx0), 0);

    // Small instance: exhaust all 32 pages, then one more.
    for (int i = 0; i < 32; i++) begin
      alloc1(idx1, fl, lat);
      check($sformatf("small_idx_%0d", i), 64'(idx1), 64'(i));
      check($sformatf("small_fail_%0d", i), 64'(fl), 0);
    end
    alloc1(idx1, fl, lat);
    check("full_fail", 64'(fl), 1);
    check("full_idx", 64'(idx1), 0);
    check("full_lat", 64'(lat), 9);
    acc = '1;
    for (int i = 0; i < 4; i++) acc &= {56'hFF_FFFF_FFFF_FFFF, mem1[i]};
    check("full_words", acc, 64'hFFFF_FFFF_FFFF_FFFF);
    free1(5'd9, er, lat);
    check("small_free_err", 64'(er), 0);
    alloc1(idx1, fl, lat);
    check("hint_kept_idx", 64'(idx1), 9);
    check("hint_kept_lat", 64'(lat), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
